// File: rtl/ctrl_exposure_fsm.sv
// Camera frame sequencer: erase while idle, expose for a clamped number of cycles,
// then run the two-row NRE/ADC readout. Every output comes straight from a flop.
module ctrl_exposure_fsm #(
  parameter int unsigned EXT_W   = 6,
  parameter int unsigned EXT_MIN = 2,
  parameter int unsigned EXT_MAX = 30
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Init,
  input  logic [EXT_W-1:0] Ex_time,
  output logic             Erase,
  output logic             Expose,
  output logic             NRE_1,
  output logic             NRE_2,
  output logic             ADC,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned CNT_W   = $clog2(EXT_MAX + 1);
  localparam int unsigned RD_W    = 3;
  localparam int unsigned RD_LAST = 5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPOSE = 2'd1,
    READ   = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] ex_cnt;
  logic [RD_W-1:0]  rd_idx;
  logic [CNT_W-1:0] ex_clamped;

  // Exposure length limited to the supported window
  always_comb begin
    ex_clamped = CNT_W'(Ex_time);
    if (Ex_time < EXT_W'(EXT_MIN)) begin
      ex_clamped = CNT_W'(EXT_MIN);
    end else if (Ex_time > EXT_W'(EXT_MAX)) begin
      ex_clamped = CNT_W'(EXT_MAX);
    end
  end

  // Outputs are loaded with the values belonging to the state being entered,
  // so they line up with the state register without any decode after the flops.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      ex_cnt <= '0;
      rd_idx <= '0;
      Erase  <= 1'b1;
      Expose <= 1'b0;
      NRE_1  <= 1'b1;
      NRE_2  <= 1'b1;
      ADC    <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      Erase  <= 1'b1;
      Expose <= 1'b0;
      NRE_1  <= 1'b1;
      NRE_2  <= 1'b1;
      ADC    <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      case (state)
        IDLE: begin
          if (Init) begin
            state  <= EXPOSE;
            ex_cnt <= ex_clamped - CNT_W'(1);
            Erase  <= 1'b0;
            Expose <= 1'b1;
            Busy   <= 1'b1;
          end
        end
        EXPOSE: begin
          Erase <= 1'b0;
          Busy  <= 1'b1;
          if (ex_cnt == '0) begin
            state  <= READ;
            rd_idx <= '0;
            NRE_1  <= 1'b0;
          end else begin
            ex_cnt <= ex_cnt - CNT_W'(1);
            Expose <= 1'b1;
          end
        end
        READ: begin
          Erase  <= 1'b0;
          Busy   <= 1'b1;
          rd_idx <= rd_idx + RD_W'(1);
          // rd_idx is the current step; outputs below are for the next step
          case (rd_idx)
            RD_W'(0): begin
              NRE_1 <= 1'b0;
              ADC   <= 1'b1;
            end
            RD_W'(1): ;
            RD_W'(2): NRE_2 <= 1'b0;
            RD_W'(3): begin
              NRE_2 <= 1'b0;
              ADC   <= 1'b1;
            end
            RD_W'(4): Done <= 1'b1;
            RD_W'(RD_LAST): begin
              state  <= IDLE;
              rd_idx <= '0;
              Erase  <= 1'b1;
              Busy   <= 1'b0;
            end
            default: begin
              state  <= IDLE;
              rd_idx <= '0;
              Erase  <= 1'b1;
              Busy   <= 1'b0;
            end
          endcase
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_exposure_fsm.sv
// Testbench for ctrl_exposure_fsm: frame-timeline reference model (frame start cycle
// plus exposure length) compared every cycle, plus scenario-specific timing checks.
module tb_ctrl_exposure_fsm;

  logic       Clk;
  logic       Reset;
  logic       Init;
  logic [5:0] Ex_time;
  logic       Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done;

  int total = 0;
  int bad   = 0;

  // Reference model: where the current frame started and how long it exposes
  int cyc    = 0;
  bit have   = 1'b0;
  int fstart = 0;
  int fn     = 0;

  ctrl_exposure_fsm dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Init   (Init),
    .Ex_time(Ex_time),
    .Erase  (Erase),
    .Expose (Expose),
    .NRE_1  (NRE_1),
    .NRE_2  (NRE_2),
    .ADC    (ADC),
    .Busy   (Busy),
    .Done   (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int clampx(input int v);
    if (v < 2) return 2;
    if (v > 30) return 30;
    return v;
  endfunction

  // The edge that ends cycle k may start a frame only if cycle k is idle
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      have = 1'b0;
    end else begin
      if (Init && (!have || cyc > fstart + fn + 6)) begin
        have   = 1'b1;
        fstart = cyc;
        fn     = clampx(int'(Ex_time));
      end
      cyc = cyc + 1;
    end
  end

  // Expected {Erase,Expose,NRE_1,NRE_2,ADC,Busy,Done} for the current cycle
  function automatic logic [6:0] exp_out();
    int d;
    int r;
    if (Reset || !have) return 7'b1011000;
    d = cyc - fstart;
    if (d >= 1 && d <= fn) return 7'b0111010;
    if (d > fn && d <= fn + 6) begin
      r = d - fn - 1;
      case (r)
        0: return 7'b0001010;
        1: return 7'b0001110;
        2: return 7'b0011010;
        3: return 7'b0010010;
        4: return 7'b0010110;
        default: return 7'b0011011;
      endcase
    end
    return 7'b1011000;
  endfunction

  function automatic logic [6:0] obs();
    return {Erase, Expose, NRE_1, NRE_2, ADC, Busy, Done};
  endfunction

  task automatic test_reset();
    Reset = 1'b1; Init = 1'b0; Ex_time = 6'd0;
    repeat (3) @(negedge Clk);
    total++;
    if (obs() !== 7'b1011000) begin
      bad++; $display("FAIL reset_vals got=%b exp=%b", obs(), 7'b1011000);
    end
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      total++;
      if (obs() !== exp_out() || obs() !== 7'b1011000) begin
        bad++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
    end
  endtask

  task automatic test_single_frame();
    int k, n_exp, n_nre1, n_nre2, n_adc, done_cyc, n_done;
    n_exp = 0; n_nre1 = 0; n_nre2 = 0; n_adc = 0; done_cyc = -1; n_done = 0;
    Init = 1'b1; Ex_time = 6'd10; k = cyc;
    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      if (i == 0) Init = 1'b0;
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL single_cycle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      if (Expose) n_exp++;
      if (!NRE_1) n_nre1++;
      if (!NRE_2) n_nre2++;
      if (ADC) n_adc++;
      if (Done) begin n_done++; done_cyc = cyc; end
    end
    total++;
    if (n_exp != 10) begin bad++; $display("FAIL single_expose_len got=%0d exp=10", n_exp); end
    total++;
    if (n_nre1 != 2 || n_nre2 != 2 || n_adc != 2) begin
      bad++; $display("FAIL single_read_counts nre1=%0d nre2=%0d adc=%0d exp=2/2/2", n_nre1, n_nre2, n_adc);
    end
    total++;
    if (n_done != 1 || done_cyc != k + 16) begin
      bad++; $display("FAIL single_done_time got=%0d count=%0d exp=%0d", done_cyc - k, n_done, 16);
    end
    total++;
    if (Erase !== 1'b1 || Busy !== 1'b0) begin
      bad++; $display("FAIL single_back_idle erase=%b busy=%b exp=1/0", Erase, Busy);
    end
  endtask

  task automatic test_clamp();
    int vals[3];
    int widths[3];
    int n_exp;
    vals = '{0, 1, 45};
    widths = '{2, 2, 30};
    for (int t = 0; t < 3; t++) begin
      n_exp = 0;
      Init = 1'b1; Ex_time = 6'(vals[t]);
      for (int i = 0; i < widths[t] + 8; i++) begin
        @(negedge Clk);
        if (i == 0) Init = 1'b0;
        total++;
        if (obs() !== exp_out()) begin
          bad++; $display("FAIL clamp_cycle ex=%0d cyc=%0d got=%b exp=%b", vals[t], cyc, obs(), exp_out());
        end
        if (Expose) n_exp++;
      end
      total++;
      if (n_exp != widths[t]) begin
        bad++; $display("FAIL clamp_width ex=%0d got=%0d exp=%0d", vals[t], n_exp, widths[t]);
      end
    end
  endtask

  task automatic test_ignore_init();
    int k, n_done, done_cyc;
    n_done = 0; done_cyc = -1;
    Init = 1'b1; Ex_time = 6'd10; k = cyc;
    for (int i = 0; i < 22; i++) begin
      @(negedge Clk);
      Init = (i == 3 || i == 12) ? 1'b1 : 1'b0;
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL ignore_cycle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      if (Done) begin n_done++; done_cyc = cyc; end
    end
    Init = 1'b0;
    total++;
    if (n_done != 1 || done_cyc != k + 16) begin
      bad++; $display("FAIL ignore_done count=%0d at=%0d exp=1 at %0d", n_done, done_cyc - k, 16);
    end
  endtask

  task automatic test_reset_abort();
    int n_done;
    n_done = 0;
    Init = 1'b1; Ex_time = 6'd10;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      Init = 1'b0;
    end
    total++;
    if (Expose !== 1'b1) begin bad++; $display("FAIL abort_pre expose=%b exp=1", Expose); end
    #1 Reset = 1'b1;
    #1;
    total++;
    if (obs() !== 7'b1011000) begin
      bad++; $display("FAIL abort_async got=%b exp=%b", obs(), 7'b1011000);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      if (Done) n_done++;
    end
    Reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      total++;
      if (obs() !== 7'b1011000) begin
        bad++; $display("FAIL abort_wait cyc=%0d got=%b exp=%b", cyc, obs(), 7'b1011000);
      end
      if (Done) n_done++;
    end
    total++;
    if (n_done != 0) begin bad++; $display("FAIL abort_no_done got=%0d exp=0", n_done); end
    Init = 1'b1; Ex_time = 6'd5;
    for (int i = 0; i < 13; i++) begin
      @(negedge Clk);
      Init = 1'b0;
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL abort_next cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      if (Done) n_done++;
    end
    total++;
    if (n_done != 1) begin bad++; $display("FAIL abort_next_done got=%0d exp=1", n_done); end
  endtask

  task automatic test_back_to_back();
    int dones[$];
    Init = 1'b1; Ex_time = 6'd2;
    for (int i = 0; i < 40; i++) begin
      @(negedge Clk);
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL b2b_cycle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      if (Done) dones.push_back(cyc);
    end
    Init = 1'b0;
    total++;
    if (dones.size() < 4) begin bad++; $display("FAIL b2b_count got=%0d exp>=4", dones.size()); end
    for (int j = 1; j < dones.size(); j++) begin
      total++;
      if (dones[j] - dones[j-1] != 9) begin
        bad++; $display("FAIL b2b_period got=%0d exp=9", dones[j] - dones[j-1]);
      end
    end
    repeat (10) @(negedge Clk);
  endtask

  task automatic test_extime_change();
    int n_exp;
    n_exp = 0;
    Init = 1'b1; Ex_time = 6'd10;
    for (int i = 0; i < 18; i++) begin
      @(negedge Clk);
      Init = 1'b0;
      if (i == 2) Ex_time = 6'd3;
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL extime_cycle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      if (Expose) n_exp++;
    end
    total++;
    if (n_exp != 10) begin bad++; $display("FAIL extime_first got=%0d exp=10", n_exp); end
    n_exp = 0;
    Init = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge Clk);
      Init = 1'b0;
      if (Expose) n_exp++;
    end
    total++;
    if (n_exp != 3) begin bad++; $display("FAIL extime_second got=%0d exp=3", n_exp); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      total++;
      if (obs() !== exp_out()) begin
        bad++; $display("FAIL random_cycle cyc=%0d got=%b exp=%b", cyc, obs(), exp_out());
      end
      Init    = ($urandom_range(0, 3) == 0);
      Ex_time = 6'($urandom_range(0, 63));
      Reset   = ($urandom_range(0, 59) == 0);
    end
    Reset = 1'b0; Init = 1'b0;
    repeat (40) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b1; Init = 1'b0; Ex_time = 6'd0;
    test_reset();
    test_single_frame();
    test_clamp();
    test_ignore_init();
    test_reset_abort();
    test_back_to_back();
    test_extime_change();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
